// File: rtl/output_port_vc_credit_ctrl_if.sv
// Port bundle between the output-port VC assignment logic and its credit controller:
// sent-flit and credit-return events in, VC offers and per-VC status out.
interface output_port_vc_credit_ctrl_if #(
  parameter int OUTPUT_VC_NUM = 4,
  parameter int VC_ID_W       = 3
);
  logic                     tx_vld_i;
  logic [VC_ID_W-1:0]       tx_vc_id_i;
  logic                     tx_head_i;
  logic                     tx_tail_i;
  logic                     crd_rtn_vld_i;
  logic [VC_ID_W-1:0]       crd_rtn_vc_id_i;
  logic                     pool_vc_vld_o;
  logic [VC_ID_W-1:0]       pool_vc_id_o;
  logic                     qos_vc_vld_o;
  logic [OUTPUT_VC_NUM-1:0] vc_busy_o;
  logic [OUTPUT_VC_NUM-1:0] vc_credit_avail_o;
  logic                     err_no_credit_o;
  logic                     err_crd_ovf_o;
  logic                     err_alloc_o;

  modport master (
    output tx_vld_i, tx_vc_id_i, tx_head_i, tx_tail_i, crd_rtn_vld_i, crd_rtn_vc_id_i,
    input  pool_vc_vld_o, pool_vc_id_o, qos_vc_vld_o, vc_busy_o, vc_credit_avail_o,
    input  err_no_credit_o, err_crd_ovf_o, err_alloc_o
  );

  modport slave (
    input  tx_vld_i, tx_vc_id_i, tx_head_i, tx_tail_i, crd_rtn_vld_i, crd_rtn_vc_id_i,
    output pool_vc_vld_o, pool_vc_id_o, qos_vc_vld_o, vc_busy_o, vc_credit_avail_o,
    output err_no_credit_o, err_crd_ovf_o, err_alloc_o
  );
endinterface

// File: rtl/output_port_vc_credit_ctrl.sv
// Per-output-port downstream VC state: credit counters, busy flags, a round-robin
// offer of one free shared-pool VC, the reserved QoS VC status and sticky error flags.
module output_port_vc_credit_ctrl #(
  parameter int OUTPUT_VC_NUM = 4,
  parameter int VC_DEPTH      = 4,
  parameter int VC_ID_W       = 3,
  parameter int CRD_W         = $clog2(VC_DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rstn,
  output_port_vc_credit_ctrl_if.slave  port_if
);

  localparam logic [CRD_W-1:0]   DEPTH_C    = CRD_W'(VC_DEPTH);
  localparam logic [VC_ID_W-1:0] LAST_VC_C  = VC_ID_W'(OUTPUT_VC_NUM - 1);
  localparam int                 ELIG_W     = 1 << VC_ID_W;

  logic [CRD_W-1:0]         credit_q [OUTPUT_VC_NUM];
  logic [CRD_W-1:0]         credit_d [OUTPUT_VC_NUM];
  logic [OUTPUT_VC_NUM-1:0] busy_q, busy_d;
  logic [VC_ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic                     err_no_credit_q, err_no_credit_d;
  logic                     err_crd_ovf_q, err_crd_ovf_d;
  logic                     err_alloc_q, err_alloc_d;

  logic                     tx_in_range, crd_in_range;
  logic                     tx_ok, crd_ok;
  logic [OUTPUT_VC_NUM-1:0] dec_v, inc_v, avail_v;
  logic [ELIG_W-1:0]        elig_v;
  logic                     pool_vld;
  logic [VC_ID_W-1:0]       pool_id;

  assign tx_in_range  = int'(port_if.tx_vc_id_i) < OUTPUT_VC_NUM;
  assign crd_in_range = int'(port_if.crd_rtn_vc_id_i) < OUTPUT_VC_NUM;
  assign tx_ok        = port_if.tx_vld_i && tx_in_range;
  assign crd_ok       = port_if.crd_rtn_vld_i && crd_in_range;

  always_comb begin
    dec_v   = '0;
    inc_v   = '0;
    avail_v = '0;
    elig_v  = '0;
    for (int v = 0; v < OUTPUT_VC_NUM; v++) begin
      dec_v[v]   = tx_ok && (port_if.tx_vc_id_i == VC_ID_W'(v));
      inc_v[v]   = crd_ok && (port_if.crd_rtn_vc_id_i == VC_ID_W'(v));
      avail_v[v] = credit_q[v] != '0;
      // VC 0 is reserved for QoS and never enters the pool search
      if (v != 0) elig_v[v] = !busy_q[v] && avail_v[v];
    end
  end

  always_comb begin
    credit_d        = credit_q;
    busy_d          = busy_q;
    rr_ptr_d        = rr_ptr_q;
    err_no_credit_d = err_no_credit_q;
    err_crd_ovf_d   = err_crd_ovf_q;
    err_alloc_d     = err_alloc_q;

    for (int v = 0; v < OUTPUT_VC_NUM; v++) begin
      // A send and a return on the same VC cancel out with no error check
      if (dec_v[v] && !inc_v[v]) begin
        if (credit_q[v] == '0) err_no_credit_d = 1'b1;
        else                   credit_d[v] = credit_q[v] - CRD_W'(1);
      end else if (inc_v[v] && !dec_v[v]) begin
        if (credit_q[v] == DEPTH_C) err_crd_ovf_d = 1'b1;
        else                        credit_d[v] = credit_q[v] + CRD_W'(1);
      end

      if (dec_v[v]) begin
        if (port_if.tx_head_i && !port_if.tx_tail_i) begin
          if (busy_q[v]) err_alloc_d = 1'b1;
          busy_d[v] = 1'b1;
        end else if (port_if.tx_tail_i && !port_if.tx_head_i) begin
          busy_d[v] = 1'b0;
        end
      end
    end

    if ((port_if.tx_vld_i && !tx_in_range) || (port_if.crd_rtn_vld_i && !crd_in_range))
      err_alloc_d = 1'b1;

    if (tx_ok && port_if.tx_head_i && (port_if.tx_vc_id_i != '0)) begin
      rr_ptr_d = (port_if.tx_vc_id_i == LAST_VC_C) ? VC_ID_W'(1)
                                                   : port_if.tx_vc_id_i + VC_ID_W'(1);
    end
  end

  // Scan from the highest offset down so the candidate nearest rr_ptr is written last
  always_comb begin
    int                 s;
    logic [VC_ID_W-1:0] idx;
    pool_vld = 1'b0;
    pool_id  = '0;
    s        = 0;
    idx      = '0;
    for (int k = OUTPUT_VC_NUM - 2; k >= 0; k--) begin
      s = int'(rr_ptr_q) + k;
      if (s > OUTPUT_VC_NUM - 1) s = s - (OUTPUT_VC_NUM - 1);
      idx = VC_ID_W'(s);
      if (elig_v[idx]) begin
        pool_vld = 1'b1;
        pool_id  = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int v = 0; v < OUTPUT_VC_NUM; v++) credit_q[v] <= DEPTH_C;
      busy_q          <= '0;
      rr_ptr_q        <= VC_ID_W'(1);
      err_no_credit_q <= 1'b0;
      err_crd_ovf_q   <= 1'b0;
      err_alloc_q     <= 1'b0;
    end else begin
      for (int v = 0; v < OUTPUT_VC_NUM; v++) credit_q[v] <= credit_d[v];
      busy_q          <= busy_d;
      rr_ptr_q        <= rr_ptr_d;
      err_no_credit_q <= err_no_credit_d;
      err_crd_ovf_q   <= err_crd_ovf_d;
      err_alloc_q     <= err_alloc_d;
    end
  end

  assign port_if.pool_vc_vld_o     = pool_vld;
  assign port_if.pool_vc_id_o      = pool_id;
  assign port_if.qos_vc_vld_o      = !busy_q[0] && avail_v[0];
  assign port_if.vc_busy_o         = busy_q;
  assign port_if.vc_credit_avail_o = avail_v;
  assign port_if.err_no_credit_o   = err_no_credit_q;
  assign port_if.err_crd_ovf_o     = err_crd_ovf_q;
  assign port_if.err_alloc_o       = err_alloc_q;

endmodule

// File: tb/tb_output_port_vc_credit_ctrl.sv
// Scoreboard bench for output_port_vc_credit_ctrl: a reference model predicts the
// full output vector each cycle; directed scenarios add named checks.
module tb_output_port_vc_credit_ctrl;
  localparam int N     = 4;
  localparam int W     = 3;
  localparam int DEPTH = 4;
  localparam int OW    = 1 + W + 1 + N + N + 3;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  output_port_vc_credit_ctrl_if #(.OUTPUT_VC_NUM(N), .VC_ID_W(W)) bus ();

  output_port_vc_credit_ctrl #(.OUTPUT_VC_NUM(N), .VC_DEPTH(DEPTH), .VC_ID_W(W)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .port_if (bus)
  );

  int  m_credit [N];
  bit  m_busy   [N];
  int  m_rr;
  bit  m_enc, m_eovf, m_ealloc;

  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] obs_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic void model_step(input bit rn, input bit tv, input int tid, input bit th,
                                     input bit tt, input bit cv, input int cid);
    if (!rn) begin
      for (int v = 0; v < N; v++) begin
        m_credit[v] = DEPTH;
        m_busy[v]   = 1'b0;
      end
      m_rr = 1; m_enc = 0; m_eovf = 0; m_ealloc = 0;
      return;
    end
    if ((tv && tid >= N) || (cv && cid >= N)) m_ealloc = 1;
    for (int v = 0; v < N; v++) begin
      int net;
      net = 0;
      if (tv && tid == v) net = net - 1;
      if (cv && cid == v) net = net + 1;
      if (net < 0) begin
        if (m_credit[v] == 0) m_enc = 1; else m_credit[v] = m_credit[v] - 1;
      end else if (net > 0) begin
        if (m_credit[v] == DEPTH) m_eovf = 1; else m_credit[v] = m_credit[v] + 1;
      end
    end
    if (tv && tid < N) begin
      if (th && !tt) begin
        if (m_busy[tid]) m_ealloc = 1;
        m_busy[tid] = 1;
      end else if (tt && !th) begin
        m_busy[tid] = 0;
      end
      if (th && tid != 0) m_rr = (tid == N - 1) ? 1 : tid + 1;
    end
  endfunction

  function automatic logic [OW-1:0] model_out();
    logic         pv;
    logic [W-1:0] pid;
    logic [N-1:0] b, a;
    pv = 0; pid = '0; b = '0; a = '0;
    for (int k = 0; k < N - 1; k++) begin
      int p;
      p = ((m_rr - 1 + k) % (N - 1)) + 1;
      if (!pv && !m_busy[p] && m_credit[p] > 0) begin
        pv  = 1;
        pid = W'(p);
      end
    end
    for (int v = 0; v < N; v++) begin
      b[v] = m_busy[v];
      a[v] = m_credit[v] > 0;
    end
    return {pv, pid, (!m_busy[0] && m_credit[0] > 0), b, a, m_enc, m_eovf, m_ealloc};
  endfunction

  function automatic logic [OW-1:0] dut_out();
    return {bus.pool_vc_vld_o, bus.pool_vc_id_o, bus.qos_vc_vld_o, bus.vc_busy_o,
            bus.vc_credit_avail_o, bus.err_no_credit_o, bus.err_crd_ovf_o, bus.err_alloc_o};
  endfunction

  task automatic step(input bit rn, input bit tv, input int tid, input bit th, input bit tt,
                      input bit cv, input int cid);
    rstn                = rn;
    bus.tx_vld_i        = tv;
    bus.tx_vc_id_i      = W'(tid);
    bus.tx_head_i       = th;
    bus.tx_tail_i       = tt;
    bus.crd_rtn_vld_i   = cv;
    bus.crd_rtn_vc_id_i = W'(cid);
    model_step(rn, tv, tid, th, tt, cv, cid);
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
    obs_q.push_back(dut_out());
  endtask

  task automatic idle();                          step(1, 0, 0, 0, 0, 0, 0);   endtask
  task automatic tx(input int id, input bit h, input bit t); step(1, 1, id, h, t, 0, 0); endtask
  task automatic crd(input int id);               step(1, 0, 0, 0, 0, 1, id);  endtask
  task automatic do_reset();                      step(0, 0, 0, 0, 0, 0, 0);   endtask

  task automatic test_reset();
    logic [OW-1:0] e, o;
    do_reset();
    idle();
    n_checks++;
    if (bus.pool_vc_vld_o !== 1'b1 || bus.pool_vc_id_o !== 3'd1 || bus.qos_vc_vld_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_offer: observed vld=%b id=%0d qos=%b required vld=1 id=1 qos=1",
               bus.pool_vc_vld_o, bus.pool_vc_id_o, bus.qos_vc_vld_o);
    end
    n_checks++;
    if (bus.vc_busy_o !== 4'h0 || bus.vc_credit_avail_o !== 4'hF ||
        {bus.err_no_credit_o, bus.err_crd_ovf_o, bus.err_alloc_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_state: observed busy=%h avail=%h err=%b%b%b required busy=0 avail=f err=000",
               bus.vc_busy_o, bus.vc_credit_avail_o, bus.err_no_credit_o, bus.err_crd_ovf_o,
               bus.err_alloc_o);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL reset_sb: observed %h required %h", o, e); end
    end
  endtask

  task automatic test_single_flit();
    logic [OW-1:0] e, o;
    tx(1, 1, 1);
    n_checks++;
    if (bus.vc_busy_o[1] !== 1'b0 || bus.pool_vc_id_o !== 3'd2) begin
      n_fail++;
      $display("FAIL single_flit: observed busy1=%b id=%0d required busy1=0 id=2",
               bus.vc_busy_o[1], bus.pool_vc_id_o);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL single_flit_sb: observed %h required %h", o, e); end
    end
  endtask

  task automatic test_same_cycle_credit();
    logic [OW-1:0] e, o;
    step(1, 1, 1, 0, 0, 1, 1);
    n_checks++;
    if ({bus.err_no_credit_o, bus.err_crd_ovf_o} !== 2'b00 || bus.vc_credit_avail_o[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL same_cycle: observed err=%b%b avail1=%b required err=00 avail1=1",
               bus.err_no_credit_o, bus.err_crd_ovf_o, bus.vc_credit_avail_o[1]);
    end
    crd(1);
    n_checks++;
    if (bus.err_crd_ovf_o !== 1'b0) begin
      n_fail++;
      $display("FAIL crd_to_full: observed ovf=%b required ovf=0", bus.err_crd_ovf_o);
    end
    crd(1);
    n_checks++;
    if (bus.err_crd_ovf_o !== 1'b1) begin
      n_fail++;
      $display("FAIL crd_ovf: observed ovf=%b required ovf=1", bus.err_crd_ovf_o);
    end
    idle();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL same_cycle_sb: observed %h required %h", o, e); end
    end
  endtask

  task automatic test_three_flit();
    logic [OW-1:0] e, o;
    tx(2, 1, 0);
    n_checks++;
    if (bus.vc_busy_o[2] !== 1'b1 || bus.pool_vc_id_o !== 3'd3) begin
      n_fail++;
      $display("FAIL pkt_head: observed busy2=%b id=%0d required busy2=1 id=3",
               bus.vc_busy_o[2], bus.pool_vc_id_o);
    end
    tx(2, 0, 0);
    n_checks++;
    if (bus.vc_busy_o[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL pkt_body: observed busy2=%b required busy2=1", bus.vc_busy_o[2]);
    end
    tx(2, 0, 1);
    n_checks++;
    if (bus.vc_busy_o[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL pkt_tail: observed busy2=%b required busy2=0", bus.vc_busy_o[2]);
    end
    idle();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL three_flit_sb: observed %h required %h", o, e); end
    end
  endtask

  task automatic test_credit_exhaust();
    logic [OW-1:0] e, o;
    step(1, 1, 3, 1, 0, 1, 3);
    for (int i = 0; i < 4; i++) tx(3, 0, 0);
    n_checks++;
    if (bus.vc_credit_avail_o[3] !== 1'b0 || bus.err_no_credit_o !== 1'b0) begin
      n_fail++;
      $display("FAIL exhaust: observed avail3=%b nc=%b required avail3=0 nc=0",
               bus.vc_credit_avail_o[3], bus.err_no_credit_o);
    end
    tx(3, 0, 0);
    n_checks++;
    if (bus.err_no_credit_o !== 1'b1 || bus.vc_credit_avail_o[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL no_credit: observed nc=%b avail3=%b required nc=1 avail3=0",
               bus.err_no_credit_o, bus.vc_credit_avail_o[3]);
    end
    crd(3);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL exhaust_sb: observed %h required %h", o, e); end
    end
  endtask

  task automatic test_alloc_errors();
    logic [OW-1:0] e, o;
    do_reset();
    tx(2, 1, 0);
    tx(2, 1, 0);
    n_checks++;
    if (bus.err_alloc_o !== 1'b1) begin
      n_fail++;
      $display("FAIL double_head: observed alloc=%b required alloc=1", bus.err_alloc_o);
    end
    do_reset();
    tx(5, 1, 0);
    n_checks++;
    if (bus.err_alloc_o !== 1'b1 || bus.vc_busy_o !== 4'h0 || bus.vc_credit_avail_o !== 4'hF) begin
      n_fail++;
      $display("FAIL tx_range: observed alloc=%b busy=%h avail=%h required alloc=1 busy=0 avail=f",
               bus.err_alloc_o, bus.vc_busy_o, bus.vc_credit_avail_o);
    end
    do_reset();
    crd(4);
    n_checks++;
    if (bus.err_alloc_o !== 1'b1 || bus.err_crd_ovf_o !== 1'b0) begin
      n_fail++;
      $display("FAIL crd_range: observed alloc=%b ovf=%b required alloc=1 ovf=0",
               bus.err_alloc_o, bus.err_crd_ovf_o);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL alloc_err_sb: observed %h required %h", o, e); end
    end
  endtask

  task automatic test_all_busy();
    logic [OW-1:0] e, o;
    do_reset();
    tx(1, 1, 0);
    tx(2, 1, 0);
    tx(3, 1, 0);
    n_checks++;
    if (bus.pool_vc_vld_o !== 1'b0 || bus.pool_vc_id_o !== 3'd0) begin
      n_fail++;
      $display("FAIL all_busy: observed vld=%b id=%0d required vld=0 id=0",
               bus.pool_vc_vld_o, bus.pool_vc_id_o);
    end
    tx(3, 0, 1);
    n_checks++;
    if (bus.pool_vc_vld_o !== 1'b1 || bus.pool_vc_id_o !== 3'd3) begin
      n_fail++;
      $display("FAIL release: observed vld=%b id=%0d required vld=1 id=3",
               bus.pool_vc_vld_o, bus.pool_vc_id_o);
    end
    tx(0, 1, 0);
    n_checks++;
    if (bus.qos_vc_vld_o !== 1'b0) begin
      n_fail++;
      $display("FAIL qos_busy: observed qos=%b required qos=0", bus.qos_vc_vld_o);
    end
    do_reset();
    n_checks++;
    if (dut_out() !== {1'b1, 3'd1, 1'b1, 4'h0, 4'hF, 3'b000}) begin
      n_fail++;
      $display("FAIL mid_pkt_reset: observed %h required %h", dut_out(),
               {1'b1, 3'd1, 1'b1, 4'h0, 4'hF, 3'b000});
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL all_busy_sb: observed %h required %h", o, e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [OW-1:0] e, o;
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) != 0), int'($urandom_range(0, 4)),
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           ($urandom_range(0, 2) != 0), int'($urandom_range(0, 4)));
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL random_sb: observed %h required %h", o, e); end
    end
  endtask

  initial begin
    rstn                = 1'b0;
    bus.tx_vld_i        = 1'b0;
    bus.tx_vc_id_i      = '0;
    bus.tx_head_i       = 1'b0;
    bus.tx_tail_i       = 1'b0;
    bus.crd_rtn_vld_i   = 1'b0;
    bus.crd_rtn_vc_id_i = '0;
    #1;
    test_reset();
    test_single_flit();
    test_same_cycle_credit();
    test_three_flit();
    test_credit_exhaust();
    test_alloc_errors();
    test_all_busy();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/output_port_vc_credit_ctrl.md
# output_port_vc_credit_ctrl

Per-output-port VC state and credit controller for the router output stage. It tracks, for each downstream VC, the credit count and allocation (busy) state. It offers one free shared-pool VC, chosen round-robin, plus the status of the reserved QoS VC. These offers are the candidate VCs that the output-port VC assignment logic selects from after switch allocation. It updates its state from the flits sent on the port and from credits returned by the downstream router.

## Interface
Parameters:
- OUTPUT_VC_NUM, 4: downstream VCs on this port. VC 0 is the reserved QoS VC; VCs 1..OUTPUT_VC_NUM-1 form the shared pool. Must be at least 2.
- VC_DEPTH, 4: downstream buffer depth per VC, in flits. This is also the reset credit value.
- VC_ID_W, 3: VC id width (rvh_noc_pkg VC_ID_NUM_MAX_W).
- CRD_W, $clog2(VC_DEPTH+1): credit counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  reset, synchronous, active-low.
- tx_vld_i  in  1  a flit leaves the port this cycle.
- tx_vc_id_i  in  VC_ID_W  downstream VC of the sent flit.
- tx_head_i  in  1  sent flit is a head flit (allocates the VC).
- tx_tail_i  in  1  sent flit is a tail flit (releases the VC). Head and tail both set means a single-flit packet.
- crd_rtn_vld_i  in  1  the downstream router returns one credit.
- crd_rtn_vc_id_i  in  VC_ID_W  VC of the returned credit.
- pool_vc_vld_o  out  1  a shared-pool VC is free and has credit.
- pool_vc_id_o  out  VC_ID_W  the offered pool VC.
- qos_vc_vld_o  out  1  VC 0 is free and has credit.
- vc_busy_o  out  OUTPUT_VC_NUM  per-VC allocated flag.
- vc_credit_avail_o  out  OUTPUT_VC_NUM  per-VC flag: credit count is greater than 0.
- err_no_credit_o  out  1  sticky: a flit was sent on a VC with 0 credits.
- err_crd_ovf_o  out  1  sticky: a credit was returned to a VC already at VC_DEPTH.
- err_alloc_o  out  1  sticky: a head flit was sent on a VC that was already busy, or a VC id was out of range.

## Operation
State:
- credit[v]: CRD_W bits.
- busy[v]: 1 bit.
- rr_ptr: VC_ID_W bits, always within the range 1..OUTPUT_VC_NUM-1.
- Three sticky error bits.

Reset values, applied when rstn=0 at a clock edge:
- credit = VC_DEPTH for every VC.
- busy = 0.
- rr_ptr = 1.
- All error bits 0.
- Resulting outputs: pool_vc_vld_o=1, pool_vc_id_o=1, qos_vc_vld_o=1, vc_busy_o=0, vc_credit_avail_o=all ones, all error outputs 0.
- Reset asserted mid-packet discards all state, including busy VCs and partially consumed credits.

Credit update, computed per VC:
- Decrement when tx_vld_i is set and tx_vc_id_i equals v.
- Increment when crd_rtn_vld_i is set and crd_rtn_vc_id_i equals v.
- Decrement and increment on the same VC in the same cycle: no change, and no error.
- Decrement at credit 0: the count holds at 0 and err_no_credit_o is set.
- Increment at VC_DEPTH: the count saturates at VC_DEPTH and err_crd_ovf_o is set.

Allocation, for a sent flit (tx_vld_i set):
- Head only: busy[v] is set. If busy[v] was already 1, err_alloc_o is set and busy stays 1.
- Tail only: busy[v] is cleared.
- Head and tail together (single-flit packet): busy[v] is unchanged, so the VC stays free.
- Body flit (neither head nor tail): busy is unchanged.
- A tx or credit-return VC id of OUTPUT_VC_NUM or above sets err_alloc_o and updates no state.

Pool offer, combinational from the registered state:
- A pool VC p is eligible when busy[p] is 0 and credit[p] is greater than 0.
- Search the eligible VCs starting at rr_ptr, increasing, and wrap from OUTPUT_VC_NUM-1 back to 1. The first eligible VC found is pool_vc_id_o.
- If no pool VC is eligible: pool_vc_vld_o=0 and pool_vc_id_o=0.
- qos_vc_vld_o = !busy[0] && credit[0] is greater than 0.

Round-robin update:
- When a head flit is sent on a pool VC p, including a single-flit packet, rr_ptr becomes p+1. If p+1 exceeds OUTPUT_VC_NUM-1, rr_ptr wraps to 1.
- Any other event leaves rr_ptr unchanged.

Error bits are sticky and are cleared only by reset.

## Timing
- Outputs are combinational functions of registers; no input feeds an output combinationally.
- A tx or credit event in cycle N is visible on the outputs in cycle N+1.
- A VC allocated by a head flit in cycle N is not offered from cycle N+1 onward. A VC released by a tail flit in cycle N is offered again from cycle N+1, provided its credit is greater than 0.
- At most one tx event and one credit return occur per cycle. They may target the same VC or different VCs in the same cycle.
- There is no backpressure on either input. The producer of tx_vld_i is responsible for gating sends on vc_credit_avail_o.

## Test plan
- Reset then idle: pool_vc_vld_o=1, pool_vc_id_o=1, qos_vc_vld_o=1, all credits at 4, no errors.
- Single-flit packet (head and tail) on VC1: next cycle busy[1]=0, credit[1]=3, rr_ptr=2, pool_vc_id_o=2.
- Three-flit packet on VC2, with head, body and tail each one cycle apart: vc_busy_o[2]=1 for exactly two cycles, pool_vc_id_o skips 2 during that window, and credit[2] ends at 1.
- Four body flits on busy VC3 with no credit returns: vc_credit_avail_o[3]=0 afterwards. A fifth flit sets err_no_credit_o=1 and credit stays 0.
- Credit 3 on VC1, then tx and credit return on VC1 in the same cycle: credit[1] stays 3 and no error is raised. A later return at 4 sets err_crd_ovf_o=1 and credit stays 4.
- VCs 1-3 all busy: pool_vc_vld_o=0 and pool_vc_id_o=0. A tail flit on VC3 brings pool_vc_vld_o=1 and pool_vc_id_o=3 one cycle later. Reset asserted mid-packet restores all reset values.
